dmem_responder: RTL

- Multi-cycle data-memory responder on the far side of the MEM-stage load/store interface; it is the slave that services the pipeline's write_ram_flag/load_ram_flag requests.
- Uses a valid/ready request and response handshake, so the pipeline can stall on memory.
- Stores bytes and halfwords through a read-modify-write state machine over a word-wide array.
- Returns loads already sign- or zero-extended.

---
 rtl/dmem_responder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: valid/ready request in, valid/ready response out,
// sub-word stores via read-modify-write. Optional macro: DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_write_flag,
    input  logic [2:0]  req_load_flag,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [1:0]    r_state;
    logic [AW+1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [1:0]    r_wflag;
    logic [2:0]    r_lflag;
    logic          r_fault;
    logic [31:0]   r_word;
    logic          r_resp_valid;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_is_load;
    logic          w_is_store;
    logic          w_half_op;
    logic          w_word_op;
    logic          w_illegal;
    logic          w_misalign;
    logic          w_fault;
    logic [AW+1:0] w_addr_cap;
    logic [AW-1:0] w_idx;
    logic [7:0]    w_lane_byte;
    logic [15:0]   w_lane_half;
    logic [31:0]   w_load_data;
    logic [31:0]   w_merge;
    logic          w_unused_addr;

    // Request decode: a single transaction is handled, so the fields are captured on handshake.
    assign w_is_load     = (req_load_flag != 3'd0);
    assign w_is_store    = (req_write_flag != 2'd0);
    assign w_half_op     = (req_load_flag == 3'd3) || (req_load_flag == 3'd4) || (req_write_flag == 2'd2);
    assign w_word_op     = (req_load_flag == 3'd5) || (req_write_flag == 2'd3);
    assign w_illegal     = (w_is_load && w_is_store) || (req_load_flag[2:1] == 2'b11);
    assign w_unused_addr = ^req_addr[31:AW+2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_misalign = (w_half_op && req_addr[0]) || (w_word_op && (req_addr[1:0] != 2'b00));
    assign w_addr_cap = req_addr[AW+1:0];
`else
    assign w_misalign = 1'b0;
    // Misaligned low bits are dropped so the access lands on the containing halfword/word.
    assign w_addr_cap = {req_addr[AW+1:2],
                         w_word_op ? 2'b00 : {req_addr[1], w_half_op ? 1'b0 : req_addr[0]}};
`endif

    assign w_fault     = w_illegal || w_misalign;
    assign w_idx       = r_addr[AW+1:2];
    assign w_lane_byte = r_word[{r_addr[1:0], 3'b000} +: 8];
    assign w_lane_half = r_word[{r_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_load_data = 32'd0;
        case (r_lflag)
            3'd1:    w_load_data = {{24{w_lane_byte[7]}}, w_lane_byte};
            3'd2:    w_load_data = {24'd0, w_lane_byte};
            3'd3:    w_load_data = {{16{w_lane_half[15]}}, w_lane_half};
            3'd4:    w_load_data = {16'd0, w_lane_half};
            3'd5:    w_load_data = r_word;
            default: w_load_data = 32'd0;
        endcase
    end

    always_comb begin
        w_merge = r_word;
        case (r_wflag)
            2'd1:    w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
            2'd2:    w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
            default: w_merge = r_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wflag      <= '0;
            r_lflag      <= '0;
            r_fault      <= 1'b0;
            r_word       <= '0;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_addr  <= w_addr_cap;
                        r_wdata <= req_wdata;
                        r_wflag <= req_write_flag;
                        r_lflag <= req_load_flag;
                        r_fault <= w_fault;
                        if (w_fault || (!w_is_load && !w_is_store))
                            r_state <= ST_RESP;
                        else if (w_is_load || (req_write_flag != 2'd3))
                            r_state <= ST_READ;
                        else
                            r_state <= ST_WRITE;
                    end
                end
                ST_READ: begin
                    r_word  <= r_mem[w_idx];
                    r_state <= (r_lflag != 3'd0) ? ST_RESP : ST_WRITE;
                end
                ST_WRITE: begin
                    r_state <= ST_RESP;
                end
                default: begin
                    // First RESP cycle formats the data; it is then held until accepted.
                    if (!r_resp_valid) begin
                        r_resp_valid <= 1'b1;
                        r_err        <= r_fault;
                        r_rdata      <= r_fault ? 32'd0 : w_load_data;
                    end else if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_err        <= 1'b0;
                        r_rdata      <= '0;
                        r_state      <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++)
                r_mem[i] <= '0;
        end else if (r_state == ST_WRITE) begin
            r_mem[w_idx] <= w_merge;
        end
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
endmodule
